i2s_frame_buf: RTL

Multi-channel successor to the stereo I2S sample latch. Captures deserialised samples per channel index into a staging register, commits a complete frame on the last channel slot, and buffers frames in a DEPTH-deep FIFO with a valid/ready output handshake. Supports swap, mute and mono-copy modes plus overflow and slot-error flags. Sits between the I2S/TDM receiver and the downstream audio processing or transmit path, in the sck domain.

---
 rtl/i2s_frame_buf_if.sv | 28 ++
 rtl/i2s_frame_buf.sv | 139 +++++++++++++
 2 files changed

// File: rtl/i2s_frame_buf_if.sv
// i2s_frame_buf_if: sample-in and frame-out signals of the I2S/TDM frame buffer.
//   data/din_vld/din_ch   : deserialised sample, its strobe and its channel (slot) index
//   out_frame/out_valid   : head-of-FIFO frame (ch0 at LSBs) and non-empty flag
//   out_ready             : consumer accepts the head frame
// Modports: master = receiver/consumer side, slave = the frame buffer itself.
interface i2s_frame_buf_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 2
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_WIDTH-1:0]        data;
    logic                         din_vld;
    logic [CH_W-1:0]              din_ch;
    logic [NUM_CH*DATA_WIDTH-1:0] out_frame;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output data, din_vld, din_ch, out_ready,
        input  out_frame, out_valid
    );

    modport slave (
        input  data, din_vld, din_ch, out_ready,
        output out_frame, out_valid
    );
endinterface

// File: rtl/i2s_frame_buf.sv
// i2s_frame_buf: multi-channel I2S/TDM frame buffer in the sck domain.
// Samples are captured per channel into a staging register; a sample on the last slot commits
// the frame (with optional swap/mute/mono transform) into a DEPTH-deep first-word-fall-through
// FIFO read through a valid/ready handshake.
//   sck, rst_n : serial clock (rising edge), asynchronous active-low reset
//   bus        : sample input and frame output handshake (i2s_frame_buf_if.slave)
//   mode       : 0 normal, 1 swap adjacent pairs, 2 mute, 3 mono (ch0 to all)
//   live_data  : untransformed staging register, ch0 at LSBs
//   level      : number of frames held in the FIFO
//   overflow   : sticky, a committed frame was dropped on a full FIFO
//   slot_err   : sticky, a channel index >= NUM_CH was seen
//   clr_err    : clears both sticky flags (a same-cycle set wins)
module i2s_frame_buf #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LVL_W     = AW + 1,
    localparam int unsigned FW        = NUM_CH * DATA_WIDTH
) (
    input  logic             sck,
    input  logic             rst_n,
    i2s_frame_buf_if.slave   bus,
    input  logic [1:0]       mode,
    output logic [FW-1:0]    live_data,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             slot_err,
    input  logic             clr_err
);
    localparam int unsigned      CHX_W    = CH_W + 1;
    localparam logic [CHX_W-1:0] NUM_CH_X = CHX_W'(NUM_CH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] stage_q [NUM_CH];
    logic [DATA_WIDTH-1:0] stage_d [NUM_CH];
    logic [DATA_WIDTH-1:0] raw     [NUM_CH];
    logic [FW-1:0]         commit_frame;
    logic [FW-1:0]         mem_q   [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  slot_err_q, slot_err_d;
    logic                  ch_ok, din_ok, commit, pop, push, ovf_set, serr_set;

    // Extra top bit so NUM_CH itself is representable when NUM_CH is a power of two.
    assign ch_ok    = {1'b0, bus.din_ch} < NUM_CH_X;
    assign din_ok   = bus.din_vld && ch_ok;
    assign commit   = bus.din_vld && (bus.din_ch == LAST_CH);
    assign pop      = (level_q != '0) && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = commit && ((level_q < FULL_LVL) || pop);
    assign ovf_set  = commit && !push;
    assign serr_set = bus.din_vld && !ch_ok;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            stage_d[i] = (din_ok && (bus.din_ch == CH_W'(i))) ? bus.data : stage_q[i];
        end
    end

    // Committed frame sees the last-slot sample written through in the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            raw[i] = (i == NUM_CH - 1) ? bus.data : stage_q[i];
        end
    end

    always_comb begin
        commit_frame = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            case (mode)
                2'd1: commit_frame[i*DATA_WIDTH +: DATA_WIDTH] =
                          raw[((i ^ 1) < NUM_CH) ? (i ^ 1) : i];
                2'd2: commit_frame[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                2'd3: commit_frame[i*DATA_WIDTH +: DATA_WIDTH] = raw[0];
                default: commit_frame[i*DATA_WIDTH +: DATA_WIDTH] = raw[i];
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Set has priority over clear.
    assign overflow_d = ovf_set  || (overflow_q && !clr_err);
    assign slot_err_d = serr_set || (slot_err_q && !clr_err);

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            slot_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            if (push) begin
                mem_q[wr_ptr_q] <= commit_frame;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            overflow_q <= overflow_d;
            slot_err_q <= slot_err_d;
        end
    end

    always_comb begin
        live_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            live_data[i*DATA_WIDTH +: DATA_WIDTH] = stage_q[i];
        end
    end

    assign bus.out_frame = mem_q[rd_ptr_q];
    assign bus.out_valid = (level_q != '0);
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign slot_err      = slot_err_q;
endmodule
